sd_card_dat_responder: RTL and testbench

SD_CARD_DAT_RESPONDER -- requirements
Module: sd_card_dat_responder

---
 rtl/sd_card_dat_responder_pkg.sv | 26 ++
 rtl/sd_crc16.sv | 28 ++
 rtl/sd_card_dat_responder.sv | 198 +++++++++++++++++++
 tb/tb_sd_card_dat_responder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_card_dat_responder_pkg.sv
// Shared types and constants for the SD card DAT-line responder.
// Holds FSM state encodings, CRC status token codes and the CRC16 polynomial.
package sd_card_dat_responder_pkg;

  typedef enum logic [3:0] {
    IDLE,
    NAC_WAIT,
    TX_START,
    TX_DATA,
    TX_CRC,
    TX_END,
    RX_WAIT,
    RX_DATA,
    RX_CRC,
    RX_END,
    NWR_WAIT,
    TOKEN,
    BUSY_HOLD,
    DONE
  } state_t;

  localparam logic [2:0]  TOK_OK   = 3'b010;
  localparam logic [2:0]  TOK_BAD  = 3'b101;
  localparam logic [15:0] CRC_POLY = 16'h1021;

endpackage

// File: rtl/sd_crc16.sv
// Serial CRC16-CCITT (x^16+x^12+x^5+1), one data bit per enabled cycle.
// Ports: sd_clock, reset (async low), clr (sync clear to 0), en, din, crc.
module sd_crc16
  import sd_card_dat_responder_pkg::*;
(
  input  logic        sd_clock,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  logic fb;

  assign fb = din ^ crc[15];

  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      crc <= '0;
    end else if (clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= {crc[14:0], 1'b0} ^ ({16{fb}} & CRC_POLY);
    end
  end

endmodule

// File: rtl/sd_card_dat_responder.sv
// Card-side SD DAT0 engine: sends read blocks, receives write blocks,
// answers with CRC status token and busy. Ports: start/writeRead/blocks
// begin a transaction; tx_* feed read words, rx_* return write words.
module sd_card_dat_responder
  import sd_card_dat_responder_pkg::*;
#(
  parameter int BLOCK_WORDS = 128,
  parameter int NAC         = 2,
  parameter int NWR         = 2,
  parameter int BUSY_CYCLES = 8
) (
  input  logic        sd_clock,
  input  logic        reset,
  input  logic        start,
  input  logic        writeRead,
  input  logic [3:0]  blocks,
  input  logic        dat_in,
  output logic        dat_out,
  output logic        dat_oe,
  input  logic [31:0] tx_data,
  output logic        tx_req,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  output logic        crc_err,
  output logic        busy,
  output logic        done
);

  localparam int DBITS = BLOCK_WORDS * 32;
  localparam int CW =
    $clog2(DBITS + NAC + NWR + BUSY_CYCLES + 16);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, len;
  logic            counted, fin;
  logic [3:0]      blk_q;
  logic            gap_q;
  logic [31:0]     shreg_q;
  logic [2:0]      tok_q;
  logic [15:0]     crc_q;
  logic            crc_clr, crc_en, crc_din;
  logic            word_end, rx_ok;

  sd_crc16 u_crc (
    .sd_clock (sd_clock),
    .reset    (reset),
    .clr      (crc_clr),
    .en       (crc_en),
    .din      (crc_din),
    .crc      (crc_q)
  );

  // Length of the timed states; fin marks their last cycle.
  always_comb begin
    len     = CW'(1);
    counted = 1'b0;
    unique case (state_q)
      NAC_WAIT: begin
        counted = 1'b1;
        // Between blocks the line idles a fixed 2 cycles.
        len = gap_q ? CW'(2) : CW'(NAC);
      end
      TX_DATA, RX_DATA: begin
        counted = 1'b1;
        len = CW'(DBITS);
      end
      TX_CRC, RX_CRC: begin
        counted = 1'b1;
        len = CW'(16);
      end
      NWR_WAIT: begin
        counted = 1'b1;
        len = CW'(NWR);
      end
      TOKEN: begin
        counted = 1'b1;
        len = CW'(5);
      end
      BUSY_HOLD: begin
        counted = 1'b1;
        len = CW'(BUSY_CYCLES);
      end
      default: ;
    endcase
  end

  assign fin   = counted && (cnt_q == len - CW'(1));
  assign cnt_d = (!counted || fin) ? '0 : cnt_q + CW'(1);
  assign word_end = (cnt_q[4:0] == 5'd31);
  assign rx_ok = dat_in && (shreg_q[15:0] == crc_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (start) begin
          if (blocks == 4'd0)  state_d = DONE;
          else if (writeRead)  state_d = RX_WAIT;
          else                 state_d = NAC_WAIT;
        end
      NAC_WAIT:  if (fin) state_d = TX_START;
      TX_START:  state_d = TX_DATA;
      TX_DATA:   if (fin) state_d = TX_CRC;
      TX_CRC:    if (fin) state_d = TX_END;
      TX_END:
        state_d = (blk_q <= 4'd1) ? DONE : NAC_WAIT;
      RX_WAIT:   if (!dat_in) state_d = RX_DATA;
      RX_DATA:   if (fin) state_d = RX_CRC;
      RX_CRC:    if (fin) state_d = RX_END;
      RX_END:    state_d = NWR_WAIT;
      NWR_WAIT:  if (fin) state_d = TOKEN;
      TOKEN:     if (fin) state_d = BUSY_HOLD;
      BUSY_HOLD:
        if (fin) state_d = (blk_q <= 4'd1) ? DONE : RX_WAIT;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    dat_out = 1'b1;
    dat_oe  = 1'b0;
    unique case (state_q)
      TX_START:  begin dat_oe = 1'b1; dat_out = 1'b0; end
      TX_DATA:   begin dat_oe = 1'b1; dat_out = shreg_q[31]; end
      TX_CRC: begin
        dat_oe  = 1'b1;
        dat_out = crc_q[4'd15 - cnt_q[3:0]];
      end
      TX_END:    dat_oe = 1'b1;
      TOKEN: begin
        dat_oe = 1'b1;
        unique case (cnt_q[2:0])
          3'd0:    dat_out = 1'b0;
          3'd1:    dat_out = tok_q[2];
          3'd2:    dat_out = tok_q[1];
          3'd3:    dat_out = tok_q[0];
          default: dat_out = 1'b1;
        endcase
      end
      BUSY_HOLD: begin dat_oe = 1'b1; dat_out = 1'b0; end
      default: ;
    endcase
  end

  assign tx_req = (state_q == TX_START) ||
                  (state_q == TX_DATA && word_end && !fin);
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign crc_clr = (state_q == TX_START) || (state_q == RX_WAIT);
  assign crc_en  = (state_q == TX_DATA) || (state_q == RX_DATA);
  assign crc_din = (state_q == TX_DATA) ? shreg_q[31] : dat_in;

  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      blk_q    <= '0;
      gap_q    <= 1'b0;
      shreg_q  <= '0;
      tok_q    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      crc_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rx_valid <= 1'b0;
      if (state_q == IDLE && start) begin
        blk_q   <= blocks;
        gap_q   <= 1'b0;
        crc_err <= 1'b0;
      end
      if (state_q == TX_END) gap_q <= 1'b1;
      if (state_q == TX_END ||
          (state_q == BUSY_HOLD && fin)) begin
        if (blk_q != 4'd0) blk_q <= blk_q - 4'd1;
      end
      if (tx_req) begin
        shreg_q <= tx_data;
      end else if (state_q == TX_DATA) begin
        shreg_q <= {shreg_q[30:0], 1'b0};
      end else if (state_q == RX_DATA ||
                   state_q == RX_CRC) begin
        shreg_q <= {shreg_q[30:0], dat_in};
      end
      if (state_q == RX_DATA && word_end) begin
        rx_valid <= 1'b1;
        rx_data  <= {shreg_q[30:0], dat_in};
      end
      if (state_q == RX_END) begin
        tok_q <= rx_ok ? TOK_OK : TOK_BAD;
        if (!rx_ok) crc_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sd_card_dat_responder.sv
// Directed bench for sd_card_dat_responder: read frames, write frames
// with good and bad CRC, zero-block transaction and mid-transfer reset.
module tb_sd_card_dat_responder;

  logic        sd_clock = 1'b0;
  logic        reset;
  logic        start;
  logic        writeRead;
  logic [3:0]  blocks;
  logic        dat_in;
  logic        dat_out;
  logic        dat_oe;
  logic [31:0] tx_data;
  logic        tx_req;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        crc_err;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  sd_card_dat_responder dut (
    .sd_clock  (sd_clock),
    .reset     (reset),
    .start     (start),
    .writeRead (writeRead),
    .blocks    (blocks),
    .dat_in    (dat_in),
    .dat_out   (dat_out),
    .dat_oe    (dat_oe),
    .tx_data   (tx_data),
    .tx_req    (tx_req),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .crc_err   (crc_err),
    .busy      (busy),
    .done      (done)
  );

  always #5 sd_clock = ~sd_clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge sd_clock);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_oe(output int n);
    n = 0;
    while (!dat_oe && n < 50) begin
      n++;
      tick();
    end
  endtask

  // Called while the start bit is on the line.
  task automatic rd_frame(input bit poke,
                          output int ones, output int oe_lo,
                          output int reqs, output int dones,
                          output logic [15:0] crc,
                          output logic sb, output logic eb);
    sb = dat_out;
    reqs = int'(tx_req);
    ones = 0; oe_lo = 0; dones = 0; crc = '0;
    for (int i = 0; i < 4096; i++) begin
      tick();
      ones  += int'(dat_out);
      oe_lo += int'(!dat_oe);
      reqs  += int'(tx_req);
      dones += int'(done);
      if (poke) start = (i == 100);
    end
    start = 1'b0;
    for (int j = 0; j < 16; j++) begin
      tick();
      crc = {crc[14:0], dat_out};
      oe_lo += int'(!dat_oe);
      reqs  += int'(tx_req);
      dones += int'(done);
    end
    tick();
    eb = dat_out;
    oe_lo += int'(!dat_oe);
    dones += int'(done);
  endtask

  task automatic wr_block(input logic [15:0] crc_tx,
                          output int nv, output int bad,
                          output int nwr, output logic [4:0] tok,
                          output int low, output logic dn);
    writeRead = 1'b1;
    blocks = 4'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    dat_in = 1'b1;
    repeat (3) tick();
    check("wr_wait_busy", busy, 1);
    check("wr_wait_oe", dat_oe, 0);
    dat_in = 1'b0;
    tick();
    nv = 0; bad = 0;
    for (int i = 0; i < 4096; i++) begin
      dat_in = 1'b0;
      tick();
      nv += int'(rx_valid);
      if (rx_valid && rx_data !== 32'h0) bad++;
    end
    for (int j = 0; j < 16; j++) begin
      dat_in = crc_tx[15-j];
      tick();
      nv += int'(rx_valid);
    end
    dat_in = 1'b1;
    tick();
    wait_oe(nwr);
    tok = '0;
    for (int k = 0; k < 5; k++) begin
      tok = {tok[3:0], dat_out};
      if (k < 4) tick();
    end
    tick();
    low = 0;
    while (dat_oe && !dat_out && low < 50) begin
      low++;
      tick();
    end
    dn = done;
  endtask

  int n, ones, oe_lo, reqs, dones, tot_reqs, nv, bad, low;
  logic [15:0] crc;
  logic sb, eb, dn;
  logic [4:0] tok;

  initial begin
    reset = 1'b0; start = 1'b0; writeRead = 1'b0;
    blocks = 4'd0; dat_in = 1'b1; tx_data = '0;
    repeat (3) tick();
    check("rst_oe", dat_oe, 0);
    check("rst_out", dat_out, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rxv", rx_valid, 0);
    check("rst_rxd", rx_data, 0);
    check("rst_err", crc_err, 0);
    check("rst_req", tx_req, 0);
    reset = 1'b1;
    tick();

    // One read block of all ones, stray start mid data.
    tx_data = 32'hFFFF_FFFF;
    writeRead = 1'b0;
    blocks = 4'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rd1_busy", busy, 1);
    wait_oe(n);
    check("rd1_nac", n, 2);
    rd_frame(1'b1, ones, oe_lo, reqs, dones, crc, sb, eb);
    check("rd1_sb", sb, 0);
    check("rd1_ones", ones, 4096);
    check("rd1_oe", oe_lo, 0);
    check("rd1_reqs", reqs, 128);
    check("rd1_nodone", dones, 0);
    check("rd1_crc", crc, 16'h7FA1);
    check("rd1_eb", eb, 1);
    tick();
    check("rd1_done", done, 1);
    check("rd1_done_oe", dat_oe, 0);
    tick();
    check("rd1_done_end", done, 0);
    check("rd1_idle", busy, 0);

    // Four read blocks of zeros.
    tx_data = 32'h0;
    blocks = 4'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    tot_reqs = 0;
    for (int b = 0; b < 4; b++) begin
      wait_oe(n);
      check("rd4_gap", n, 2);
      rd_frame(1'b0, ones, oe_lo, reqs, dones, crc, sb, eb);
      tot_reqs += reqs;
      check("rd4_ones", ones, 0);
      check("rd4_crc", crc, 16'h0000);
      check("rd4_eb", eb, 1);
      check("rd4_nodone", dones, 0);
      tick();
    end
    check("rd4_done", done, 1);
    check("rd4_reqs", tot_reqs, 512);
    tick();

    // Write block with correct CRC.
    wr_block(16'h0000, nv, bad, n, tok, low, dn);
    check("wr_nv", nv, 128);
    check("wr_rxd", bad, 0);
    check("wr_nwr", n, 2);
    check("wr_tok", tok, 5'b00101);
    check("wr_busy", low, 8);
    check("wr_done", dn, 1);
    check("wr_err", crc_err, 0);
    tick();

    // Write block with a flipped CRC bit.
    wr_block(16'h0400, nv, bad, n, tok, low, dn);
    check("wrb_nv", nv, 128);
    check("wrb_tok", tok, 5'b01011);
    check("wrb_busy", low, 8);
    check("wrb_done", dn, 1);
    check("wrb_err", crc_err, 1);
    repeat (3) tick();
    check("wrb_err_hold", crc_err, 1);

    // Zero-block transaction; also clears crc_err.
    writeRead = 1'b0;
    blocks = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("z_done", done, 1);
    check("z_oe", dat_oe, 0);
    check("z_err_clr", crc_err, 0);
    tick();
    check("z_done_end", done, 0);
    check("z_idle", busy, 0);

    // Reset in the middle of read data.
    tx_data = 32'hA5A5_A5A5;
    blocks = 4'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_oe(n);
    repeat (20) tick();
    check("mr_oe_pre", dat_oe, 1);
    #2 reset = 1'b0;
    #1;
    check("mr_oe", dat_oe, 0);
    check("mr_out", dat_out, 1);
    check("mr_busy", busy, 0);
    dones = 0;
    repeat (4) begin
      tick();
      dones += int'(done);
    end
    reset = 1'b1;
    tick();
    dones += int'(done);
    check("mr_nodone", dones, 0);
    check("mr_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
